// File: rtl/bgm_tone_gen.sv
// bgm_tone_gen: square-wave tone generator with a linear attack/release
// envelope. Converts the sequencer's half-period divider into the signed
// background-music sample stream consumed by the audio mixer.
module bgm_tone_gen #(
    parameter int unsigned ENV_STEP = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] note_div,
    input  logic [3:0]  vol_num,
    input  logic        mute,
    output logic [15:0] audio,
    output logic [4:0]  env_level,
    output logic        active
);

    localparam int unsigned DIV_W  = 22;
    localparam int unsigned ENV_W  = 5;
    localparam int unsigned AUD_W  = 16;
    localparam int unsigned PROD_W = AUD_W + ENV_W;
    localparam int unsigned TMR_W  = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ENV_STEP - 1);
    localparam logic [ENV_W-1:0] ENV_MAX  = ENV_W'(16);
    localparam logic [AUD_W-1:0] AMP_MIN  = AUD_W'(16'h0400);

    typedef enum logic [1:0] {
        SILENT  = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   cur_div;
    logic [DIV_W-1:0]   cur_div_nxt;
    logic [DIV_W-1:0]   hp_cnt;
    logic [DIV_W-1:0]   hp_cnt_nxt;
    logic               ph;
    logic               ph_nxt;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_nxt;
    logic [ENV_W-1:0]   env;
    logic [ENV_W-1:0]   env_nxt;
    logic [AUD_W-1:0]   amp;
    logic [AUD_W-1:0]   amp_nxt;
    logic               step;
    logic               leave;
    logic [PROD_W-1:0]  prod;
    logic [AUD_W-1:0]   mag;
    logic [AUD_W-1:0]   smp;

    // Volume level to peak amplitude lookup
    always_comb begin
        amp_nxt = AMP_MIN;
        case (vol_num)
            4'd5:    amp_nxt = AUD_W'(16'h4000);
            4'd4:    amp_nxt = AUD_W'(16'h3000);
            4'd3:    amp_nxt = AUD_W'(16'h2000);
            4'd2:    amp_nxt = AUD_W'(16'h1000);
            4'd1:    amp_nxt = AUD_W'(16'h0800);
            default: amp_nxt = AMP_MIN;
        endcase
    end

    // Envelope FSM, tone phase and step timer next-state logic
    always_comb begin
        state_nxt   = state;
        cur_div_nxt = cur_div;
        hp_cnt_nxt  = hp_cnt;
        ph_nxt      = ph;
        env_nxt     = env;
        tmr_nxt     = tmr;
        step        = (tmr == TMR_LAST);
        leave       = mute || (note_div != cur_div);

        // Half-period counter keeps running through release so the fade
        // follows the old pitch rather than a frozen level.
        if (state != SILENT) begin
            if (hp_cnt == (cur_div - DIV_W'(1))) begin
                hp_cnt_nxt = '0;
                ph_nxt     = ~ph;
            end else begin
                hp_cnt_nxt = hp_cnt + DIV_W'(1);
            end
        end

        case (state)
            SILENT: begin
                env_nxt    = '0;
                hp_cnt_nxt = '0;
                ph_nxt     = 1'b0;
                if ((note_div != '0) && !mute) begin
                    state_nxt   = ATTACK;
                    cur_div_nxt = note_div;
                    ph_nxt      = 1'b1;
                end
            end
            ATTACK: begin
                if (leave) begin
                    state_nxt = RELEASE;
                end else if (step) begin
                    if (env >= (ENV_MAX - ENV_W'(1))) begin
                        env_nxt   = ENV_MAX;
                        state_nxt = SUSTAIN;
                    end else begin
                        env_nxt = env + ENV_W'(1);
                    end
                end
            end
            SUSTAIN: begin
                env_nxt = ENV_MAX;
                if (leave) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (step) begin
                    if (env <= ENV_W'(1)) begin
                        env_nxt   = '0;
                        state_nxt = SILENT;
                    end else begin
                        env_nxt = env - ENV_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = SILENT;
                env_nxt   = '0;
            end
        endcase

        // Timer restarts on every state entry and after each step
        if ((state_nxt != state) || step) begin
            tmr_nxt = '0;
        end else begin
            tmr_nxt = tmr + TMR_W'(1);
        end
    end

    // Scaled magnitude and signed square-wave sample
    always_comb begin
        prod = PROD_W'(amp) * PROD_W'(env);
        mag  = AUD_W'(prod >> 4);
        smp  = ph ? mag : ((~mag) + AUD_W'(1));
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SILENT;
            cur_div <= '0;
            hp_cnt  <= '0;
            ph      <= 1'b0;
            tmr     <= '0;
            env     <= '0;
            amp     <= AMP_MIN;
        end else begin
            state   <= state_nxt;
            cur_div <= cur_div_nxt;
            hp_cnt  <= hp_cnt_nxt;
            ph      <= ph_nxt;
            tmr     <= tmr_nxt;
            env     <= env_nxt;
            amp     <= amp_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            audio  <= '0;
            active <= 1'b0;
        end else begin
            audio  <= smp;
            active <= (state_nxt != SILENT);
        end
    end

    assign env_level = env;

endmodule

// File: tb/tb_bgm_tone_gen.sv
// Directed bench for bgm_tone_gen with ENV_STEP=4 (one envelope step
// every 4 cycles, full attack or release in 64 cycles).
module tb_bgm_tone_gen;

    logic        clk;
    logic        rst;
    logic [21:0] note_div;
    logic [3:0]  vol_num;
    logic        mute;
    logic [15:0] audio;
    logic [4:0]  env_level;
    logic        active;

    int checks = 0;
    int errors = 0;

    bgm_tone_gen #(.ENV_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .note_div  (note_div),
        .vol_num   (vol_num),
        .mute      (mute),
        .audio     (audio),
        .env_level (env_level),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        note_div = 22'd0;
        vol_num  = 4'd5;
        mute     = 1'b0;

        // Reset values, no clock edge yet
        #3;
        chk("rst_audio", 32'(audio), 32'h0);
        chk("rst_env", 32'(env_level), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);
        chk("idle_env", 32'(env_level), 32'd0);
        chk("idle_active", 32'(active), 32'd0);

        // 1. Basic note: P = now
        note_div = 22'd10;
        tick(1);                                   // P+1
        chk("t1_active", 32'(active), 32'd1);
        chk("t1_env_start", 32'(env_level), 32'd0);
        tick(3);                                   // P+4
        chk("t1_env_pre", 32'(env_level), 32'd0);
        tick(1);                                   // P+5
        chk("t1_env_1", 32'(env_level), 32'd1);
        chk("t1_audio_lat", 32'(audio), 32'h0);
        tick(1);                                   // P+6
        chk("t1_audio_first", 32'(audio), 32'h0400);
        tick(59);                                  // P+65
        chk("t1_env_16", 32'(env_level), 32'd16);
        tick(6);                                   // P+71
        chk("t1_pos", 32'(audio), 32'h4000);
        tick(1);                                   // P+72
        chk("t1_neg", 32'(audio), 32'hC000);
        tick(9);                                   // P+81
        chk("t1_neg_end", 32'(audio), 32'hC000);
        tick(1);                                   // P+82
        chk("t1_pos2", 32'(audio), 32'h4000);
        chk("t1_active2", 32'(active), 32'd1);

        // 2. Note change 10 -> 20 in sustain
        note_div = 22'd20;
        tick(5);                                   // P+87
        chk("t2_env_15", 32'(env_level), 32'd15);
        tick(28);                                  // P+115
        chk("t2_env_8", 32'(env_level), 32'd8);
        tick(1);                                   // P+116
        chk("t2_audio_half", 32'(audio), 32'hE000);
        tick(30);                                  // P+146
        chk("t2_env_1", 32'(env_level), 32'd1);
        chk("t2_active_rel", 32'(active), 32'd1);
        tick(1);                                   // P+147 = Q (silent)
        chk("t2_env_0", 32'(env_level), 32'd0);
        chk("t2_silent", 32'(active), 32'd0);
        chk("t2_audio_last", 32'(audio), 32'h0400);
        tick(1);                                   // Q+1
        chk("t2_reattack", 32'(active), 32'd1);
        chk("t2_silent_audio", 32'(audio), 32'h0);
        tick(64);                                  // Q+65
        chk("t2_env_16", 32'(env_level), 32'd16);
        tick(16);                                  // Q+81
        chk("t2_hp20_a", 32'(audio), 32'hC000);
        tick(1);                                   // Q+82
        chk("t2_hp20_b", 32'(audio), 32'h4000);
        tick(19);                                  // Q+101
        chk("t2_hp20_c", 32'(audio), 32'h4000);
        tick(1);                                   // Q+102
        chk("t2_hp20_d", 32'(audio), 32'hC000);

        // 3. Back to 10, hold, then mute
        note_div = 22'd10;
        tick(65);                                  // Q+167 = R (silent)
        chk("t3_silent", 32'(active), 32'd0);
        tick(1);                                   // R+1
        chk("t3_attack", 32'(active), 32'd1);
        tick(64);                                  // R+65
        chk("t3_env_16", 32'(env_level), 32'd16);
        tick(235);                                 // R+300
        chk("t3_hold_mid", 32'(env_level), 32'd16);
        tick(265);                                 // R+565
        chk("t3_hold_end", 32'(env_level), 32'd16);
        chk("t3_hold_active", 32'(active), 32'd1);
        mute = 1'b1;
        tick(64);                                  // R+629
        chk("t3_mute_env1", 32'(env_level), 32'd1);
        chk("t3_mute_act", 32'(active), 32'd1);
        tick(1);                                   // R+630
        chk("t3_mute_env0", 32'(env_level), 32'd0);
        chk("t3_mute_silent", 32'(active), 32'd0);
        tick(1);                                   // R+631
        chk("t3_mute_audio", 32'(audio), 32'h0);
        tick(50);                                  // R+681 = S
        chk("t3_held_audio", 32'(audio), 32'h0);
        chk("t3_held_active", 32'(active), 32'd0);
        chk("t3_held_env", 32'(env_level), 32'd0);

        // 4. Volume steps in sustain
        mute = 1'b0;
        tick(65);                                  // S+65
        chk("t4_env_16", 32'(env_level), 32'd16);
        tick(5);                                   // S+70
        vol_num = 4'd2;
        tick(1);                                   // S+71
        chk("t4_vol_lat", 32'(audio), 32'h4000);
        tick(1);                                   // S+72
        chk("t4_vol2", 32'(audio), 32'hF000);
        vol_num = 4'd9;
        tick(2);                                   // S+74
        chk("t4_vol9", 32'(audio), 32'hFC00);
        chk("t4_env_kept", 32'(env_level), 32'd16);
        chk("t4_active", 32'(active), 32'd1);

        // 5. Rest during attack, then minimum divider
        note_div = 22'd0;
        vol_num  = 4'd5;
        tick(66);                                  // S+140 = T
        chk("t5_rest_silent", 32'(active), 32'd0);
        chk("t5_rest_env", 32'(env_level), 32'd0);
        note_div = 22'd10;
        tick(29);                                  // T+29
        chk("t5_env_7", 32'(env_level), 32'd7);
        note_div = 22'd0;
        tick(1);                                   // T+30
        chk("t5_rel_keep7", 32'(env_level), 32'd7);
        chk("t5_rel_active", 32'(active), 32'd1);
        tick(4);                                   // T+34
        chk("t5_rel_6", 32'(env_level), 32'd6);
        tick(23);                                  // T+57
        chk("t5_rel_1", 32'(env_level), 32'd1);
        tick(1);                                   // T+58 = U
        chk("t5_rel_0", 32'(env_level), 32'd0);
        chk("t5_rel_silent", 32'(active), 32'd0);
        note_div = 22'd1;
        tick(1);                                   // U+1
        chk("t5_div1_active", 32'(active), 32'd1);
        tick(65);                                  // U+66
        chk("t5_div1_a", 32'(audio), 32'h4000);
        tick(1);                                   // U+67
        chk("t5_div1_b", 32'(audio), 32'hC000);
        tick(1);                                   // U+68
        chk("t5_div1_c", 32'(audio), 32'h4000);
        chk("t5_div1_env", 32'(env_level), 32'd16);

        // 6. Async reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        chk("t6_async_audio", 32'(audio), 32'h0);
        chk("t6_async_env", 32'(env_level), 32'd0);
        chk("t6_async_active", 32'(active), 32'd0);
        note_div = 22'd10;
        @(posedge clk);
        #1;
        rst = 1'b1;                                // W
        chk("t6_post_env", 32'(env_level), 32'd0);
        chk("t6_post_active", 32'(active), 32'd0);
        tick(1);                                   // W+1
        chk("t6_fresh_active", 32'(active), 32'd1);
        chk("t6_fresh_env0", 32'(env_level), 32'd0);
        tick(4);                                   // W+5
        chk("t6_fresh_env1", 32'(env_level), 32'd1);
        tick(1);                                   // W+6
        chk("t6_fresh_audio", 32'(audio), 32'h0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bgm_tone_gen.md
# bgm_tone_gen

Square-wave tone generator with a per-note amplitude envelope, placed between the melody sequencer and the audio mixer. It consumes the 22-bit half-period divider emitted by `background_music` and produces the signed 16-bit `bgm_audio` sample stream that `audio_mixer` combines with sound effects. Note changes fade out and fade in rather than cutting abruptly, which removes clicks at note boundaries and at rests.

## Interface
- `ENV_STEP`, default 50000: clk cycles per envelope step. At 100 MHz, 50000 cycles is 0.5 ms per step, so a full attack or release of 16 steps takes 8 ms.
- `clk`, input, 1: system clock (100 MHz). `note_div` counts half-periods in these cycles.
- `rst`, input, 1: asynchronous, active-low reset.
- `note_div`, input, 22: half-period length in clk cycles. The value 0 means rest (silence).
- `vol_num`, input, 4: volume level, 0..15.
- `mute`, input, 1: when 1, force fade-out and hold silence.
- `audio`, output, 16: signed two's-complement sample that feeds the mixer's `bgm_audio` input.
- `env_level`, output, 5: current envelope value, 0..16.
- `active`, output, 1: 1 in every state except SILENT.

## Operation
- **Amplitude register `amp`** is updated every cycle from `vol_num`:
  - 5 → 0x4000
  - 4 → 0x3000
  - 3 → 0x2000
  - 2 → 0x1000
  - 1 → 0x0800
  - 0 and 6..15 → 0x0400
- **Magnitude:** `mag = (amp * env) >> 4`. Compute the product in at least 19 bits. With env=16, `mag` equals `amp`; with env=0, `mag` is 0.
- **Sample:** `audio = ph ? mag : -mag`, in two's complement. The negation of 0 is 0.
- **Tone:**
  - `cur_div` holds the note latched at attack start.
  - `hp_cnt` counts 0..`cur_div`-1. On reaching `cur_div`-1 it wraps to 0 and `ph` toggles.
  - With `cur_div`=1, `ph` toggles every cycle.
  - The tone runs in ATTACK, SUSTAIN and RELEASE.
- **Envelope timer:** `tmr` counts 0..`ENV_STEP`-1 and is cleared to 0 on every state entry. An envelope step occurs on the cycle where `tmr` equals `ENV_STEP`-1.
- **FSM states:**
  - SILENT: env=0, `hp_cnt`=0, `ph`=0. If `note_div`≠0 and `mute`=0: latch `cur_div`←`note_div`, set `ph`←1 and `hp_cnt`←0, then go to ATTACK.
  - ATTACK: env increments by 1 on each step. Reaching 16 goes to SUSTAIN. If `mute`=1 or `note_div`≠`cur_div`, go to RELEASE, keeping the current env.
  - SUSTAIN: env stays at 16. If `mute`=1 or `note_div`≠`cur_div`, go to RELEASE.
  - RELEASE: env decrements by 1 on each step. Input changes are ignored until env reaches 0; then go to SILENT.
- **Boundaries:**
  - Repeated identical `note_div` values from the sequencer never retrigger the envelope.
  - A note change during RELEASE takes effect only after SILENT is reached.
  - Entering RELEASE from ATTACK with env=0 (before the first step) goes to SILENT on the next step.
  - A change of `vol_num` never affects the FSM; only the magnitude changes.
  - The env counter saturates and never wraps.
  - After RELEASE, SILENT always lasts at least one cycle.

## Timing
- **Reset:** while `rst`=0, independent of `clk`:
  - Outputs: `audio`=0, `env_level`=0, `active`=0.
  - Internal state: SILENT, `cur_div`=0, `hp_cnt`=0, `ph`=0, `tmr`=0, `amp`=0x0400.
  - Reset asserted mid-note silences the output immediately.
- **Registered outputs:** all outputs are registered. `audio` at cycle n+1 reflects `ph`, `env` and `amp` at cycle n.
- **Start latency:** if `note_div` becomes nonzero at cycle 0 while in SILENT:
  - cycle 1: state is ATTACK and `active`=1.
  - cycle 1+`ENV_STEP`: env=1.
  - one cycle later: `audio` becomes nonzero.
- **Attack and release length:** each takes exactly 16×`ENV_STEP` cycles from state entry.
- **Volume latency:** a `vol_num` change is visible on `audio` after 2 cycles (`amp` register, then `audio` register).

## Test plan
1. **Basic note.** `ENV_STEP`=4, `vol_num`=5, `note_div`: 0→10. Required: `env_level` reaches 16 64 cycles after ATTACK entry; `audio` then alternates +0x4000 / 0xC000, changing sign every 10 cycles; `active`=1.
2. **Note change.** `note_div` 10→20 while in SUSTAIN. Required: `env_level` ramps 16→0 over 64 cycles while `ph` keeps a 10-cycle half period; SILENT lasts 1 cycle with `audio`=0; then the new attack runs with a 20-cycle half period.
3. **Hold and mute.** `note_div` held at 10 for 500 cycles, then `mute`=1. Required: no retrigger during the hold (`env_level` stays at 16); after mute, the release completes, `active`=0, `audio`=0 and stays 0 while muted.
4. **Volume steps.** In SUSTAIN, `vol_num` 5→2. Required: `|audio|`=0x1000 within 2 cycles. Then `vol_num`=9. Required: `|audio|`=0x0400.
5. **Rest and minimum divider.**
   - Change `note_div`→0 during ATTACK at env=7. Required: release from 7 to 0 over 28 cycles.
   - Then set `note_div`=1. Required: after the attack, `audio` sign flips every cycle.
6. **Async reset.** Assert `rst`=0 mid-SUSTAIN, between clock edges. Required: `audio`=0, `env_level`=0 and `active`=0 immediately. After release of reset with `note_div`=10 held, a fresh attack starts from env=0.
